// File: rtl/apb_master_bridge_if.sv
// Signal bundle for apb_master_bridge: command port, response port and APB4 bus.
// The master modport is the bridge's view; the slave modport is the view of
// whatever surrounds it (request logic on one side, the APB slave on the other).
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // Command port
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic [DATA_WIDTH/8-1:0] cmd_strb;
  // Response port
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;
  logic                    rsp_timeout;
  // APB4 bus
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic                    PSELx;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic                    PREADY;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  rsp_ready,
    output PADDR, PSELx, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output rsp_ready,
    input  PADDR, PSELx, PENABLE, PWRITE, PWDATA, PSTRB,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB4 requester: turns one valid/ready command into one SETUP->ACCESS transfer
// and returns the slave's answer on a valid/ready response port. A wait-state
// counter aborts the transfer if the slave holds PREADY low for TIMEOUT cycles.
// DATA_WIDTH must be 8, 16 or 32; TIMEOUT must be in 1..255.
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_master_bridge_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // The counter holds at most TIMEOUT (<= 255); the abort fires on the edge
  // where it would step from TIMEOUT-1 to TIMEOUT.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  // Ready only in IDLE and never while reset is held.
  assign bus.cmd_ready = (state == IDLE) && PRESETn;

  // Transfer FSM with registered bus and response outputs; the async reset
  // drops the bus and discards any pending response immediately.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      bus.PADDR       <= '0;
      bus.PSELx       <= 1'b0;
      bus.PENABLE     <= 1'b0;
      bus.PWRITE      <= 1'b0;
      bus.PWDATA      <= '0;
      bus.PSTRB       <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.PADDR  <= bus.cmd_addr;
            bus.PWRITE <= bus.cmd_write;
            // Reads keep the previous PWDATA and carry no strobes.
            if (bus.cmd_write) begin
              bus.PWDATA <= bus.cmd_wdata;
              bus.PSTRB  <= bus.cmd_strb;
            end else begin
              bus.PSTRB  <= '0;
            end
            bus.PSELx <= 1'b1;
            state     <= SETUP;
          end
        end

        SETUP: begin
          bus.PENABLE <= 1'b1;
          state       <= ACCESS;
        end

        ACCESS: begin
          if (bus.PREADY) begin
            bus.rsp_rdata   <= bus.PWRITE ? '0 : bus.PRDATA;
            bus.rsp_err     <= bus.PSLVERR;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.PSELx       <= 1'b0;
            bus.PENABLE     <= 1'b0;
            state           <= RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            // Slave is hung: abandon the transfer and report it.
            wait_cnt        <= wait_cnt + 8'd1;
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b1;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_valid   <= 1'b1;
            bus.PSELx       <= 1'b0;
            bus.PENABLE     <= 1'b0;
            state           <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            wait_cnt      <= '0;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: a directed table of transfers, a reset-in-ACCESS
// sequence and a randomized run scored against a transaction-level model.
module tb_apb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic PCLK;
  logic PRESETn;

  apb_master_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_wdata;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;   // PREADY-low cycles the slave inserts
    logic [31:0] prdata;
    logic        slverr;
    int          bp;      // cycles of rsp_ready=0 in RESP
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_access;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transaction-level expectation from the bridge's rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_to     = (v.waits >= TO);
    r.exp_access = r.exp_to ? TO : v.waits + 1;
    r.exp_rdata  = (r.exp_to || v.wr) ? 32'h0 : v.prdata;
    r.exp_err    = r.exp_to ? 1'b1 : v.slverr;
    return r;
  endfunction

  // Protocol rule: PENABLE only with PSELx, and never in PSELx's first cycle.
  logic prev_psel = 1'b0;
  always @(negedge PCLK) begin
    if (PRESETn && bus.PENABLE)
      check("penable_rule", 32'({bus.PSELx, prev_psel}), 32'h3);
    prev_psel = bus.PSELx;
  end

  // One full transfer; entered and left at a falling edge.
  task automatic run_xfer(input vec_t v);
    logic        ok;
    logic        acc_ok;
    logic        stable;
    logic [31:0] exp_pw;
    logic [3:0]  exp_ps;
    int          acc;
    bit          done;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.cmd_strb  = v.strb;
    bus.cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.cmd_ready) begin ok = 1'b1; break; end
      @(negedge PCLK);
    end
    check("cmd_accept", 32'(ok), 32'h1);
    if (!ok) begin bus.cmd_valid = 1'b0; return; end
    @(posedge PCLK); @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    exp_pw = v.wr ? v.wdata : last_wdata;
    exp_ps = v.wr ? v.strb : 4'h0;
    if (v.wr) last_wdata = v.wdata;
    // SETUP cycle
    check("setup_sel_en", 32'({bus.PSELx, bus.PENABLE}), 32'h2);
    check("setup_paddr",  bus.PADDR, v.addr);
    check("setup_pwrite", 32'(bus.PWRITE), 32'(v.wr));
    check("setup_pwdata", bus.PWDATA, exp_pw);
    check("setup_pstrb",  32'(bus.PSTRB), 32'(exp_ps));
    check("setup_busy",   32'({bus.cmd_ready, bus.rsp_valid}), 32'h0);
    @(posedge PCLK); @(negedge PCLK);
    // ACCESS cycles, slave answering after v.waits cycles
    acc = 0; done = 0; acc_ok = 1'b1;
    while (!done) begin
      acc_ok &= bus.PSELx && bus.PENABLE && (bus.PADDR == v.addr) &&
                (bus.PWDATA == exp_pw) && (bus.PSTRB == exp_ps) && !bus.rsp_valid;
      if (acc == v.waits) begin
        bus.PREADY = 1'b1; bus.PRDATA = v.prdata; bus.PSLVERR = v.slverr;
      end else begin
        bus.PREADY = 1'b0; bus.PRDATA = $urandom; bus.PSLVERR = 1'($urandom_range(0, 1));
      end
      acc++;
      @(posedge PCLK); @(negedge PCLK);
      if (bus.PREADY || !bus.PSELx || acc >= 40) done = 1;
    end
    bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    check("access_bus_stable", 32'(acc_ok), 32'h1);
    check("access_cycles", 32'(acc), 32'(v.exp_access));
    // RESP
    check("rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("rsp_bus_idle", 32'({bus.PSELx, bus.PENABLE}), 32'h0);
    check("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    check("rsp_err", 32'(bus.rsp_err), 32'(v.exp_err));
    check("rsp_timeout", 32'(bus.rsp_timeout), 32'(v.exp_to));
    stable = 1'b1;
    for (int i = 0; i < v.bp; i++) begin
      bus.cmd_valid = 1'b1;
      @(posedge PCLK); @(negedge PCLK);
      stable &= bus.rsp_valid && (bus.rsp_rdata == v.exp_rdata) &&
                (bus.rsp_err == v.exp_err) && (bus.rsp_timeout == v.exp_to) &&
                !bus.cmd_ready && !bus.PSELx;
    end
    if (v.bp > 0) check("rsp_backpressure_stable", 32'(stable), 32'h1);
    bus.rsp_ready = 1'b1;
    @(posedge PCLK); @(negedge PCLK);
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    check("post_handshake", 32'({bus.rsp_valid, bus.cmd_ready, bus.PSELx}), 32'h2);
  endtask

  vec_t tbl[6];
  vec_t rv;

  initial begin
    // wr addr wdata strb waits prdata slverr bp | rdata err to access
    tbl[0] = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 0,  32'h0,        1'b0, 0, 32'h0,        1'b0, 1'b0, 1};
    tbl[1] = '{1'b0, 32'h04, 32'h11111111, 4'hA, 3,  32'hDEADBEEF, 1'b0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 4};
    tbl[2] = '{1'b1, 32'hFC, 32'hCAFEF00D, 4'h3, 2,  32'h0,        1'b1, 0, 32'h0,        1'b1, 1'b0, 3};
    tbl[3] = '{1'b0, 32'h10, 32'h0,        4'h0, 20, 32'h55AA55AA, 1'b0, 0, 32'h0,        1'b1, 1'b1, 16};
    tbl[4] = '{1'b0, 32'h20, 32'h0,        4'hF, 0,  32'h12345678, 1'b0, 5, 32'h12345678, 1'b0, 1'b0, 1};
    tbl[5] = '{1'b1, 32'h30, 32'hA5A5A5A5, 4'h9, 1,  32'hFFFFFFFF, 1'b0, 0, 32'h0,        1'b0, 1'b0, 2};

    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0;   bus.cmd_strb = '0;    bus.rsp_ready = 1'b0;
    bus.PREADY = 1'b0;    bus.PRDATA = '0;      bus.PSLVERR = 1'b0;
    last_wdata = 32'h0;
    PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    check("reset_ctrl", 32'({bus.PSELx, bus.PENABLE, bus.PWRITE, bus.rsp_valid,
                             bus.rsp_err, bus.rsp_timeout}), 32'h0);
    check("reset_paddr", bus.PADDR, 32'h0);
    check("reset_pwdata", bus.PWDATA, 32'h0);
    check("reset_pstrb", 32'(bus.PSTRB), 32'h0);
    check("reset_rdata", bus.rsp_rdata, 32'h0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("ready_after_reset", 32'(bus.cmd_ready), 32'h1);

    for (int i = 0; i < 6; i++) run_xfer(tbl[i]);

    // Reset during an ACCESS wait state
    bus.cmd_write = 1'b0; bus.cmd_addr = 32'h08; bus.cmd_strb = 4'h0; bus.cmd_valid = 1'b1;
    @(posedge PCLK); @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    @(posedge PCLK); @(negedge PCLK);
    bus.PREADY = 1'b0;
    @(posedge PCLK); @(negedge PCLK);
    check("pre_reset_in_access", 32'({bus.PSELx, bus.PENABLE}), 32'h3);
    #1 PRESETn = 1'b0;
    #1 check("async_reset_drop", 32'({bus.PSELx, bus.PENABLE, bus.rsp_valid}), 32'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    last_wdata = 32'h0;
    @(negedge PCLK);
    rv = '{1'b0, 32'h00, 32'h0, 4'hF, 1, 32'h0BADF00D, 1'b0, 0, 32'h0, 1'b0, 1'b0, 0};
    run_xfer(model(rv));

    // Randomized transfers scored against the model
    for (int n = 0; n < 40; n++) begin
      rv.wr     = 1'($urandom_range(0, 1));
      rv.addr   = {$urandom_range(0, 255), 2'b00};
      rv.wdata  = $urandom;
      rv.strb   = 4'($urandom_range(0, 15));
      rv.waits  = ($urandom_range(0, 7) == 0) ? TO + 2 : $urandom_range(0, 5);
      rv.prdata = $urandom;
      rv.slverr = ($urandom_range(0, 3) == 0);
      rv.bp     = $urandom_range(0, 3);
      run_xfer(model(rv));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB4 requester (initiator) that drives the APB slave/register-file interface from a simple valid/ready command port.
- Converts each accepted command into one APB SETUP→ACCESS transfer, waits for PREADY, and returns PRDATA/PSLVERR on a valid/ready response port.
- Sits between on-chip request logic (or a bench sequencer) and the APB bus.
- Adds a wait-state timeout so a hung slave cannot stall the requester.

Parameters:
- ADDR_WIDTH, 32, width of PADDR and cmd_addr.
- DATA_WIDTH, 32, width of PWDATA/PRDATA; must be 8, 16 or 32. PSTRB width is DATA_WIDTH/8.
- TIMEOUT, 16, maximum number of ACCESS cycles with PREADY low before the transfer is aborted; legal range 1..255.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESETn  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge accepts command.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  PSLVERR sampled or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PADDR  out  ADDR_WIDTH  APB address.
- PSELx  out  1  slave select.
- PENABLE  out  1  access phase.
- PWRITE  out  1  direction.
- PWDATA  out  DATA_WIDTH  write data.
- PSTRB  out  DATA_WIDTH/8  write strobes.
- PREADY  in  1  slave ready.
- PRDATA  in  DATA_WIDTH  slave read data.
- PSLVERR  in  1  slave error.

Behaviour:
- Reset (PRESETn low, async): state=IDLE; PSELx, PENABLE, PWRITE, rsp_valid, rsp_err and rsp_timeout are 0; PADDR, PWDATA, PSTRB and rsp_rdata are 0; wait counter is 0. cmd_ready is 1 once reset is released.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, register addr, write, wdata and strb onto the P* outputs, then go to SETUP.
  - PSTRB is forced to 0 for reads.
  - PWDATA is held at its last value on reads.
- SETUP (exactly 1 cycle): PSELx=1, PENABLE=0, cmd_ready=0; next state is ACCESS.
- ACCESS:
  - PSELx=1, PENABLE=1.
  - PADDR, PWRITE, PWDATA and PSTRB are held stable for the whole state.
  - If PREADY=1 at a clock edge:
    - Capture rsp_rdata = PRDATA for reads, 0 for writes.
    - rsp_err=PSLVERR, rsp_timeout=0.
    - Drop PSELx and PENABLE, go to RESP.
  - If PREADY=0: increment the wait counter.
  - If the counter reaches TIMEOUT with PREADY still 0:
    - Drop PSELx and PENABLE.
    - rsp_err=1, rsp_timeout=1, rsp_rdata=0.
    - Go to RESP.
  - PSLVERR is ignored while PREADY=0.
- RESP:
  - rsp_valid=1; response fields stay stable until rsp_ready=1.
  - On rsp_valid&&rsp_ready: rsp_valid→0, clear the wait counter, go to IDLE.
  - There is no back-to-back pipelining: the next SETUP is at least 1 cycle after the handshake.
- Latency with zero wait states:
  - Command accepted at edge T → SETUP in cycle T..T+1.
  - ACCESS in cycle T+1..T+2, PREADY sampled at edge T+2.
  - rsp_valid high in the cycle after edge T+2.
  - Each wait state adds 1 cycle.
- Reset mid-transfer: the bus drops immediately (PSELx and PENABLE to 0 asynchronously) and any pending response is discarded.
- The bridge never asserts PENABLE without PSELx, and never asserts PENABLE in the first cycle of PSELx.
- Commands presented while cmd_ready=0 are not consumed; cmd_valid may stay high.

Test Plan:
- Write, zero wait: cmd addr=0x04, wdata=0xDEADBEEF, strb=0xF → SETUP 1 cycle, ACCESS 1 cycle with PWDATA=0xDEADBEEF and PSTRB=0xF; rsp_valid 3 cycles after accept with rsp_err=0 and rsp_rdata=0.
- Read, 3 wait states: read addr=0x04, slave holds PREADY=0 for 3 cycles then returns PRDATA=0xDEADBEEF → ACCESS lasts 4 cycles; PADDR stable throughout; PSTRB=0; rsp_rdata=0xDEADBEEF.
- Slave error: write to addr=0xFC with PSLVERR=1 and PREADY=1 → rsp_err=1, rsp_timeout=0; PSLVERR=1 while PREADY=0 is ignored.
- Timeout: TIMEOUT=16, PREADY tied 0 → PSELx drops after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0; next command proceeds normally.
- Response backpressure: rsp_ready=0 for 5 cycles with cmd_valid held high → rsp fields stable, cmd_ready=0, no new SETUP; 1 cycle after the handshake, cmd_ready=1 and the next SETUP starts.
- Reset in ACCESS: assert PRESETn=0 during a wait state → PSELx, PENABLE and rsp_valid go to 0 without waiting for a clock edge; after release, a read of 0x00 completes normally.
